// File: rtl/fpu_req_sequencer.sv
// Command sequencer for the FPU start/ready protocol: buffers host commands,
// issues them one at a time and returns each result with its latency.
module fpu_req_sequencer #(
  parameter int REG_SIZE  = 32,
  parameter int OP_BITS   = 2,
  parameter int DEPTH     = 4,
  parameter int START_LEN = 4,
  parameter int TIMEOUT   = 62
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_BITS-1:0]  cmd_op,
  input  logic [REG_SIZE-1:0] cmd_a,
  input  logic [REG_SIZE-1:0] cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OP_BITS-1:0]  rsp_op,
  output logic [REG_SIZE-1:0] rsp_a,
  output logic [REG_SIZE-1:0] rsp_b,
  output logic [REG_SIZE-1:0] rsp_res,
  output logic [5:0]          rsp_cycles,
  output logic                rsp_timeout,
  output logic                fpu_start,
  output logic [OP_BITS-1:0]  fpu_op,
  output logic [REG_SIZE-1:0] fpu_a,
  output logic [REG_SIZE-1:0] fpu_b,
  input  logic [REG_SIZE-1:0] fpu_res,
  input  logic                fpu_ready,
  output logic                busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t state, state_next;

  logic [OP_BITS-1:0]  fifo_op [DEPTH];
  logic [REG_SIZE-1:0] fifo_a  [DEPTH];
  logic [REG_SIZE-1:0] fifo_b  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                full, empty, push, pop;

  logic [5:0]          cnt, cnt_next, cnt_inc;
  logic                to_flag, to_next;
  logic                ready_q, ready_edge;
  logic [REG_SIZE-1:0] iss_b_raw;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // Issue only once the response slot is free or is being drained this cycle.
  assign pop       = (state == IDLE) && !empty && (!rsp_valid || rsp_ready);

  assign ready_edge = fpu_ready && !ready_q;
  assign cnt_inc    = (cnt == 6'd63) ? cnt : cnt + 6'd1;
  assign fpu_start  = (state == START);
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_op;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      to_flag <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      to_flag <= to_next;
      ready_q <= fpu_ready;
    end
  end

  // The counter holds on the cycle that leaves WAIT, so it reports the edge cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    to_next    = to_flag;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = START;
          cnt_next   = '0;
          to_next    = 1'b0;
        end
      end
      START: begin
        cnt_next = cnt_inc;
        if (cnt == 6'(START_LEN - 1)) state_next = WAIT;
      end
      WAIT: begin
        if (ready_edge) begin
          state_next = DONE;
        end else if (cnt >= 6'(TIMEOUT)) begin
          state_next = DONE;
          to_next    = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_op    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      iss_b_raw <= '0;
    end else if (pop) begin
      fpu_op    <= fifo_op[rd_ptr];
      fpu_a     <= fifo_a[rd_ptr];
      fpu_b     <= fifo_op[rd_ptr][0] ? '0 : fifo_b[rd_ptr];
      iss_b_raw <= fifo_b[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_a       <= '0;
      rsp_b       <= '0;
      rsp_res     <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
    end else if (state == DONE) begin
      rsp_valid   <= 1'b1;
      rsp_op      <= fpu_op;
      rsp_a       <= fpu_a;
      rsp_b       <= iss_b_raw;
      rsp_res     <= to_flag ? '0 : fpu_res;
      rsp_cycles  <= cnt;
      rsp_timeout <= to_flag;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Scoreboard bench for fpu_req_sequencer: random commands, a behavioural FPU
// model with per-command latency plans, and a decoupled response monitor.
module tb_fpu_req_sequencer;

  localparam int REG_SIZE  = 32;
  localparam int OP_BITS   = 2;
  localparam int DEPTH     = 4;
  localparam int START_LEN = 4;
  localparam int TIMEOUT   = 62;

  localparam int MODE_NORMAL  = 0;
  localparam int MODE_STALE   = 1;
  localparam int MODE_TIMEOUT = 2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    int          lat;
  } plan_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] cycles;
    logic [31:0] to;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready;
  logic [OP_BITS-1:0]  cmd_op;
  logic [REG_SIZE-1:0] cmd_a, cmd_b;
  logic                rsp_valid, rsp_ready;
  logic [OP_BITS-1:0]  rsp_op;
  logic [REG_SIZE-1:0] rsp_a, rsp_b, rsp_res;
  logic [5:0]          rsp_cycles;
  logic                rsp_timeout;
  logic                fpu_start;
  logic [OP_BITS-1:0]  fpu_op;
  logic [REG_SIZE-1:0] fpu_a, fpu_b;
  logic [REG_SIZE-1:0] fpu_res = '0;
  logic                fpu_ready = 1'b0;
  logic                busy;

  int    check_count = 0;
  int    pass_count  = 0;
  bit    rand_ready  = 0;
  plan_t plan_q[$];
  exp_t  exp_q[$];

  fpu_req_sequencer #(
    .REG_SIZE(REG_SIZE), .OP_BITS(OP_BITS), .DEPTH(DEPTH),
    .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_res(rsp_res),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res(fpu_res), .fpu_ready(fpu_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Stand-in for the FPU datapath: exact for the known vectors, a rough
  // exponent-arithmetic approximation otherwise.
  function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[0]) begin
      if (a == 32'h4180_0000) return 32'h4080_0000;
      return (a >> 1) + 32'h1FC0_0000;
    end
    if (a == 32'h40A0_0000 && b == 32'h4000_0000) return 32'h4020_0000;
    return a - b + 32'h3F80_0000;
  endfunction

  function automatic exp_t model_rsp(input plan_t p);
    exp_t e;
    e.op     = p.op;
    e.a      = p.a;
    e.b      = p.b;
    e.to     = (p.mode == MODE_TIMEOUT) ? 32'd1 : 32'd0;
    e.res    = (p.mode == MODE_TIMEOUT) ? 32'd0 : fpu_fn(p.op, p.a, p.b);
    e.cycles = (p.mode == MODE_TIMEOUT) ? 32'(TIMEOUT) : 32'(START_LEN + p.lat);
    return e;
  endfunction

  // FPU model: follows the plan of each issued command in order.
  plan_t cur;
  bit    have_cur = 0;
  bit    prev_start = 0;
  int    countdown = -1;
  int    start_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 0;
      have_cur   = 0;
      countdown  = -1;
      fpu_ready  = 1'b0;
    end else begin
      if (fpu_start && !prev_start) begin
        if (plan_q.size() == 0) begin
          checkOutput("unexpected_fpu_start", 32'd1, 32'd0);
          have_cur = 0;
        end else begin
          cur      = plan_q.pop_front();
          have_cur = 1;
        end
        fpu_ready  = have_cur && (cur.mode == MODE_STALE);
        countdown  = -1;
        start_seen = 0;
      end
      if (fpu_start) start_seen++;
      if (have_cur) begin
        checkOutput("fpu_op", 32'(fpu_op), 32'(cur.op));
        checkOutput("fpu_a", fpu_a, cur.a);
        checkOutput("fpu_b", fpu_b, cur.op[0] ? 32'd0 : cur.b);
      end
      if (!fpu_start && prev_start && have_cur) begin
        checkOutput("start_len", 32'(start_seen), 32'(START_LEN));
        if (cur.mode == MODE_STALE) fpu_ready = 1'b0;
        if (cur.mode != MODE_TIMEOUT) countdown = cur.lat;
      end else if (countdown > 0) begin
        countdown--;
      end
      if (countdown == 0 && have_cur) begin
        fpu_res   = fpu_fn(cur.op, cur.a, cur.b);
        fpu_ready = 1'b1;
        countdown = -1;
      end
      prev_start = fpu_start;
    end
  end

  // Response monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_op", 32'(rsp_op), 32'(e.op));
        checkOutput("rsp_a", rsp_a, e.a);
        checkOutput("rsp_b", rsp_b, e.b);
        checkOutput("rsp_res", rsp_res, e.res);
        checkOutput("rsp_cycles", 32'(rsp_cycles), e.cycles);
        checkOutput("rsp_timeout", 32'(rsp_timeout), e.to);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int mode, input int lat, input int max_wait);
    bit    accepted = 0;
    plan_t p;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < max_wait && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        p.op = op; p.a = a; p.b = b; p.mode = mode; p.lat = lat;
        plan_q.push_back(p);
        exp_q.push_back(model_rsp(p));
        accepted = 1;
      end
      @(posedge clk);
      #1;
      if (!accepted && rand_ready) rsp_ready = ($urandom_range(0, 1) == 1);
    end
    cmd_valid = 1'b0;
    checkOutput("push_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    rsp_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    checkOutput("drain_exp", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_plan", 32'(plan_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit held_off;
    int rsp_seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_fpu_start", 32'(fpu_start), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_res", rsp_res, 32'd0);
    checkOutput("reset_fpu_b", fpu_b, 32'd0);

    $display("[TB] single divide");
    applyStimulus(2'd0, 32'h40A0_0000, 32'h4000_0000, MODE_NORMAL, 20, 50);
    waitDrain(200);

    $display("[TB] sqrt");
    applyStimulus(2'd1, 32'h4180_0000, 32'hFFFF_FFFF, MODE_NORMAL, 7, 50);
    waitDrain(200);

    $display("[TB] fifo full / backpressure");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, MODE_NORMAL, $urandom_range(0, 15), 20);
    checkOutput("cmd_ready_full", 32'(cmd_ready), 32'd0);
    held_off  = 1;
    cmd_valid = 1'b1;
    cmd_op = 2'd2; cmd_a = 32'h1234_5678; cmd_b = 32'h3F80_0000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready) held_off = 0;
    end
    cmd_valid = 1'b0;
    checkOutput("cmd_ready_held_low", 32'(held_off), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    applyStimulus(2'd2, 32'h1234_5678, 32'h3F80_0000, MODE_NORMAL, 3, 300);
    waitDrain(600);

    $display("[TB] stale ready");
    applyStimulus(2'd0, 32'h4100_0000, 32'h4040_0000, MODE_STALE, 10, 50);
    waitDrain(200);

    $display("[TB] timeout then normal");
    applyStimulus(2'd0, 32'h4280_0000, 32'h4000_0000, MODE_TIMEOUT, 0, 50);
    applyStimulus(2'd1, 32'h4110_0000, 32'h0, MODE_NORMAL, 5, 50);
    waitDrain(300);

    $display("[TB] random traffic");
    rand_ready = 1;
    for (int i = 0; i < 20; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, MODE_NORMAL, $urandom_range(0, 40), 400);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1 rsp_ready = ($urandom_range(0, 1) == 1);
      end
    end
    rand_ready = 0;
    waitDrain(2000);

    $display("[TB] async reset in WAIT");
    for (int i = 0; i < 4; i++)
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, MODE_TIMEOUT, 0, 50);
    repeat (6) @(posedge clk);
    checkOutput("busy_before_reset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_fpu_start", 32'(fpu_start), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid || fpu_start) rsp_seen++;
    end
    checkOutput("no_activity_after_reset", 32'(rsp_seen), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
